// File: rtl/axis_heartbeat_if.sv
`timescale 1ns/1ps
// axis_heartbeat_if: AXI-Stream bundle between the heartbeat source and its consumer
interface axis_heartbeat_if #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 9,
   parameter int USER_WIDTH = 97
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   modport master (output tdata, tkeep, tvalid, tlast, tuser, tid, tdest, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/axis_heartbeat_gen.sv
`timescale 1ns/1ps
// axis_heartbeat_gen: periodic Ethernet heartbeat frame source with req/grant arbitration
module axis_heartbeat_gen #(
   parameter int          AXIS_DATA_WIDTH = 64,
   parameter int          AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int          AXIS_ID_WIDTH   = 1,
   parameter int          AXIS_DEST_WIDTH = 9,
   parameter int          AXIS_USER_WIDTH = 97,
   parameter int          PERIOD_WIDTH    = 32,
   parameter int          FRAME_LEN       = 64,
   parameter logic [47:0] DST_MAC         = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC         = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETHERTYPE       = 16'h88B5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic                    req,
   input  logic                    grant,
   axis_heartbeat_if.master        m_axis,
   output logic [31:0]             seq_num,
   output logic [15:0]             missed
);
   localparam int BEATS      = (FRAME_LEN + AXIS_KEEP_WIDTH - 1) / AXIS_KEEP_WIDTH;
   localparam int LAST_BYTES = FRAME_LEN - (BEATS - 1) * AXIS_KEEP_WIDTH;
   localparam int BW         = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [AXIS_KEEP_WIDTH-1:0] LAST_KEEP =
      {AXIS_KEEP_WIDTH{1'b1}} >> (AXIS_KEEP_WIDTH - LAST_BYTES);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2;

   logic [1:0]                       state;
   logic [PERIOD_WIDTH-1:0]          cnt;
   logic                             run, tick, pending, valid, last;
   logic [BW-1:0]                    beat;
   logic [143:0]                     hdr;
   logic [BEATS*AXIS_DATA_WIDTH-1:0] frame;

   assign run  = enable && period != '0;
   assign tick = run && cnt + PERIOD_WIDTH'(1) == period;

   // period counter: restarts on every tick and whenever it is stopped
   always_ff @(posedge clk)
      if (rst || !run || tick) cnt <= '0;
      else cnt <= cnt + PERIOD_WIDTH'(1);

   // frame sequencing: tick -> pending -> request -> granted send; ticks during a frame are only counted
   always_ff @(posedge clk)
      if (rst) begin
         state   <= IDLE;
         pending <= 1'b0;
         req     <= 1'b0;
         valid   <= 1'b0;
         beat    <= '0;
         seq_num <= '0;
         missed  <= '0;
      end else begin
         if (tick && state != IDLE && missed != 16'hFFFF) missed <= missed + 16'd1;
         case (state)
            IDLE: begin
               if (tick) pending <= 1'b1;
               if (pending) begin
                  state <= REQ;
                  req   <= 1'b1;
               end
            end
            REQ: if (grant) begin
               state <= SEND;
               valid <= 1'b1;
               beat  <= '0;
            end
            SEND: if (m_axis.tready) begin
               if (last) begin
                  state   <= IDLE;
                  req     <= 1'b0;
                  valid   <= 1'b0;
                  pending <= 1'b0;
                  seq_num <= seq_num + 32'd1;
               end else beat <= beat + BW'(1);
            end
            default: state <= IDLE;
         endcase
      end

   assign hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq_num};

   // first wire byte goes to the lowest byte lane; everything past the header is zero padding
   always_comb begin
      frame = '0;
      for (int i = 0; i < 18; i++) frame[8*i +: 8] = hdr[143 - 8*i -: 8];
   end

   assign last          = beat == LAST_BEAT;
   assign m_axis.tvalid = valid;
   assign m_axis.tdata  = valid ? frame[beat*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] : '0;
   assign m_axis.tkeep  = valid ? (last ? LAST_KEEP : '1) : '0;
   assign m_axis.tlast  = valid && last;
   assign m_axis.tuser  = '0;
   assign m_axis.tid    = '0;
   assign m_axis.tdest  = '0;
endmodule
